// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   AN_U1..AN_U4, AN_OFF : active-low one-hot anode patterns
//   digit_idx_t          : 2-bit display slot index (0 = U1 .. 3 = U4)
//   slot_state_t         : per-slot phase, BLANK (anodes off) then SCAN
//   an_for()             : anode pattern for a slot index
package seg_pkg;

  localparam logic [3:0] AN_U1  = 4'b1110;
  localparam logic [3:0] AN_U2  = 4'b1101;
  localparam logic [3:0] AN_U3  = 4'b1011;
  localparam logic [3:0] AN_U4  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } slot_state_t;

  function automatic logic [3:0] an_for(input digit_idx_t idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = AN_U1;
      2'd1:    pat = AN_U2;
      2'd2:    pat = AN_U3;
      default: pat = AN_U4;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Slot timer: counts REFRESH_DIV cycles per digit slot, BLANK for the first
// BLANK_CYC of them and SCAN for the rest, and walks the slot index 0..3.
//   clk, rst       : clock, synchronous active-high reset
//   state          : current slot phase (BLANK/SCAN)
//   idx            : current slot index
//   frame_start_c  : combinational strobe, first BLANK cycle of slot 0
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst,
  output slot_state_t state,
  output digit_idx_t  idx,
  output logic        frame_start_c
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  slot_state_t      state_next;
  digit_idx_t       idx_next;
  logic             slot_end_c;

  assign slot_end_c    = (state == SCAN) && (cnt == SLOT_LAST);
  assign frame_start_c = (state == BLANK) && (cnt == '0) && (idx == 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state: counter runs through the whole slot, index advances at slot end
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_next = SCAN;
      end
      SCAN: begin
        if (slot_end_c) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
        end
      end
      default: state_next = BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment hh:mm:ss display.
// Blanks between digits, shows mm:ss (page 0) or hh:mm (page 1) from a
// per-frame snapshot of the time, and blinks selected digits.
//   clk, rst    : clock, synchronous active-high reset
//   count       : 24-bit BCD time, [23:20] hour tens .. [3:0] second units
//   page_btn    : debounced level, rising edge requests a page toggle
//   blink_mask  : bit i blinks digit U(i+1)
//   an          : active-low one-hot digit enable
//   digit       : BCD nibble for the scanned digit
//   dp          : active-low decimal point (lit on U3)
//   page        : 0 = mm:ss, 1 = hh:mm
//   frame_tick  : one-cycle pulse at each frame start
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] count,
  input  logic        page_btn,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        page,
  output logic        frame_tick
);

  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  slot_state_t      state;
  digit_idx_t       idx;
  logic             frame_start_c;

  logic [23:0]      snap;
  logic             page_btn_q;
  logic             pending;
  logic             blink_phase;
  logic [BLK_W-1:0] blink_cnt;

  logic             page_rise_c;
  logic [3:0]       nib;
  logic [3:0]       an_next;
  logic             dp_next;

  seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .state         (state),
    .idx           (idx),
    .frame_start_c (frame_start_c)
  );

  assign page_rise_c = page_btn & ~page_btn_q;

  // Nibble for the current slot from the frame snapshot
  always_comb begin
    nib = 4'h0;
    case ({page, idx})
      3'b000:  nib = snap[3:0];
      3'b001:  nib = snap[7:4];
      3'b010:  nib = snap[11:8];
      3'b011:  nib = snap[15:12];
      3'b100:  nib = snap[11:8];
      3'b101:  nib = snap[15:12];
      3'b110:  nib = snap[19:16];
      default: nib = snap[23:20];
    endcase
  end

  // Anode and decimal point for the current slot; blinked slots stay dark
  always_comb begin
    an_next = AN_OFF;
    dp_next = 1'b1;
    if (state == SCAN) begin
      if (!(blink_mask[idx] && blink_phase)) an_next = an_for(idx);
      if (idx == 2'd2) dp_next = 1'b0;
    end
  end

  // Output registers plus per-frame snapshot, page and blink bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= AN_OFF;
      digit       <= 4'h0;
      dp          <= 1'b1;
      page        <= 1'b0;
      frame_tick  <= 1'b0;
      snap        <= 24'h0;
      page_btn_q  <= 1'b0;
      pending     <= 1'b0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
    end else begin
      an         <= an_next;
      dp         <= dp_next;
      digit      <= nib;
      frame_tick <= frame_start_c;
      page_btn_q <= page_btn;
      if (frame_start_c) begin
        snap    <= count;
        // an edge arriving on the boundary cycle itself counts for this frame
        page    <= page ^ (pending | page_rise_c);
        pending <= 1'b0;
        if (blink_cnt == BLK_LAST) begin
          blink_phase <= ~blink_phase;
          blink_cnt   <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else if (page_rise_c) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed events followed by random
// stimulus, compared every cycle against a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] count;
  logic        page_btn;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp;
  logic        page;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: time since reset in state-cycles, plus frame-level state
  int          m_s;
  logic [23:0] m_snap;
  logic        m_page, m_pend, m_phase, m_prev;
  int          m_bcnt;
  logic [3:0]  e_an, e_digit;
  logic        e_dp, e_page, e_tick, e_dchk;

  seg_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .page_btn   (page_btn),
    .blink_mask (blink_mask),
    .an         (an),
    .digit      (digit),
    .dp         (dp),
    .page       (page),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_snap = 24'h0; m_page = 1'b0; m_pend = 1'b0;
    m_phase = 1'b0; m_prev = 1'b0; m_bcnt = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at the edge
  task automatic model_edge();
    int          pos, slot;
    logic        bnd, scan, rise;
    logic [3:0]  oh;
    logic [23:0] sh;
    if (rst) begin
      model_reset();
      e_an = 4'hF; e_digit = 4'h0; e_dp = 1'b1; e_page = 1'b0; e_tick = 1'b0;
      e_dchk = 1'b1;
    end else begin
      pos  = m_s % RD;
      slot = (m_s / RD) % 4;
      bnd  = (m_s % FRAME) == 0;
      scan = pos >= BC;
      oh   = 4'b0001 << slot;
      e_an = (!scan || (blink_mask[slot] && m_phase)) ? 4'hF : ~oh;
      e_dp = !(scan && slot == 2);
      sh   = m_snap >> (4 * slot + (m_page ? 8 : 0));
      e_digit = sh[3:0];
      e_dchk  = scan;
      e_tick  = bnd;
      rise = page_btn && !m_prev;
      if (bnd) begin
        m_page = m_page ^ (m_pend | rise);
        m_pend = 1'b0;
        m_snap = count;
        if (m_bcnt + 1 == BF) begin
          m_phase = ~m_phase;
          m_bcnt  = 0;
        end else begin
          m_bcnt = m_bcnt + 1;
        end
      end else if (rise) begin
        m_pend = 1'b1;
      end
      m_prev = page_btn;
      e_page = m_page;
      m_s++;
    end
  endtask

  initial begin
    bit bdone, rdone;
    int brel;
    bdone = 0; rdone = 0; brel = -1;
    rst = 1'b1; count = 24'h123456; page_btn = 1'b0; blink_mask = 4'h0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 3);
      case (c)
        45:  count = 24'h235959;      // mid slot 1 of the second frame
        100: count = 24'h123456;
        110: page_btn = 1'b1;         // single pulse
        112: page_btn = 1'b0;
        170: page_btn = 1'b1;         // two pulses inside one frame
        172: page_btn = 1'b0;
        174: page_btn = 1'b1;
        176: page_btn = 1'b0;
        200: blink_mask = 4'b0001;
        500: blink_mask = 4'b0000;
        700: blink_mask = 4'b1010;
        default: ;
      endcase
      // page edge landing exactly on a frame boundary
      if (c >= 520 && !bdone && (m_s % FRAME) == 0) begin
        page_btn = 1'b1; bdone = 1; brel = c + 2;
      end
      if (c == brel) page_btn = 1'b0;
      // reset during the SCAN of U3
      if (c >= 600 && !rdone && (m_s % FRAME) == 2 * RD + 4) begin
        rst = 1'b1; rdone = 1;
      end
      if (c >= 700) begin
        if ($urandom_range(0, 39) == 0) count = 24'($urandom);
        if ($urandom_range(0, 24) == 0) page_btn = ~page_btn;
        if ($urandom_range(0, 199) == 0) blink_mask = 4'($urandom);
        if ($urandom_range(0, 599) == 0) rst = 1'b1;
      end
      @(posedge clk);
      model_edge();
      #1;
      check("an", 32'(an), 32'(e_an));
      check("dp", 32'(dp), 32'(e_dp));
      check("page", 32'(page), 32'(e_page));
      check("frame_tick", 32'(frame_tick), 32'(e_tick));
      if (e_dchk) check("digit", 32'(digit), 32'(e_digit));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
